// File: rtl/fix_to_custom_float.sv
// Signed fixed-point to custom float {sign, exp bias 127, mantissa} converter, 3-stage pipeline.
// Optional macro FIX2FLT_INEXACT_EN adds out_inexact and a saturating inexact_cnt.
module fix_to_custom_float #(
  parameter int unsigned word_length = 24,
  parameter int unsigned int_bits    = 12,
  parameter int unsigned frac_bits   = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [int_bits+frac_bits-1:0] in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [word_length+7:0]        out_data,
  output logic                          out_valid,
`ifdef FIX2FLT_INEXACT_EN
  output logic                          out_inexact,
  output logic [15:0]                   inexact_cnt,
`endif
  input  logic                          out_ready
);

  localparam int unsigned N  = int_bits + frac_bits;
  localparam int unsigned M  = word_length - 1;
  localparam int unsigned PW = $clog2(N);
  localparam int unsigned XW = N + M;
  localparam logic [7:0] ExpBase = 8'(127 - frac_bits);

  if (frac_bits > 126 || int_bits > 127) begin : g_param_check
    $error("fix_to_custom_float: exponent range exceeded by frac_bits/int_bits");
  end

  logic                 adv;
  logic                 s1_valid_q, s1_valid_d, s1_sign_q, s1_sign_d;
  logic [N-1:0]         s1_mag_q, s1_mag_d;
  logic                 s2_valid_q, s2_valid_d, s2_sign_q, s2_sign_d, s2_zero_q, s2_zero_d;
  logic [N-1:0]         s2_mag_q, s2_mag_d;
  logic [PW-1:0]        s2_pos_q, s2_pos_d, pos;
  logic                 out_valid_q, out_valid_d;
  logic [word_length+7:0] out_data_q, out_data_d;

  logic [PW-1:0]        shamt;
  logic [N-1:0]         norm;
  logic [XW-1:0]        ext;
  logic [M-1:0]         mant;
  logic                 guard, sticky, rnd_up;
  logic [M:0]           mant_r;
  logic [7:0]           exp_b;

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Highest set bit wins: later iterations overwrite earlier ones.
  always_comb begin
    pos = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (s1_mag_q[i]) pos = PW'(i);
    end
  end

  // Left-justify bits below the leading one; pad so guard/sticky always exist.
  always_comb begin
    shamt  = PW'(N - 1) - s2_pos_q;
    norm   = s2_mag_q << shamt;
    ext    = {norm[N-2:0], {(M + 1){1'b0}}};
    mant   = ext[XW-1 -: M];
    guard  = ext[N-1];
    sticky = |ext[N-2:0];
    rnd_up = guard & (sticky | mant[0]);
    mant_r = {1'b0, mant} + {{M{1'b0}}, rnd_up};
    exp_b  = ExpBase + 8'(s2_pos_q) + 8'(mant_r[M]);
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_sign_d   = s1_sign_q;
    s1_mag_d    = s1_mag_q;
    s2_valid_d  = s2_valid_q;
    s2_sign_d   = s2_sign_q;
    s2_zero_d   = s2_zero_q;
    s2_mag_d    = s2_mag_q;
    s2_pos_d    = s2_pos_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (adv) begin
      s1_valid_d  = in_valid;
      s1_sign_d   = in_data[N-1];
      s1_mag_d    = in_data[N-1] ? (~in_data + 1'b1) : in_data;
      s2_valid_d  = s1_valid_q;
      s2_sign_d   = s1_sign_q;
      s2_zero_d   = (s1_mag_q == '0);
      s2_mag_d    = s1_mag_q;
      s2_pos_d    = pos;
      out_valid_d = s2_valid_q;
      out_data_d  = s2_zero_q ? '0 : {s2_sign_q, exp_b, mant_r[M-1:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_mag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_zero_q   <= 1'b1;
      s2_mag_q    <= '0;
      s2_pos_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_mag_q    <= s1_mag_d;
      s2_valid_q  <= s2_valid_d;
      s2_sign_q   <= s2_sign_d;
      s2_zero_q   <= s2_zero_d;
      s2_mag_q    <= s2_mag_d;
      s2_pos_q    <= s2_pos_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef FIX2FLT_INEXACT_EN
  logic        inexact_q, inexact_d;
  logic [15:0] cnt_q, cnt_d;

  assign out_inexact = inexact_q;
  assign inexact_cnt = cnt_q;

  always_comb begin
    inexact_d = inexact_q;
    cnt_d     = cnt_q;
    if (adv) inexact_d = guard | sticky;
    if (out_valid_q && out_ready && inexact_q && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inexact_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      inexact_q <= inexact_d;
      cnt_q     <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_fix_to_custom_float.sv
// Bench: two instances (24/12/12 and 8/12/12) share stimulus; arithmetic reference model + scoreboard.
module tb_fix_to_custom_float;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_ready24, in_ready8, ov24, ov8;
  logic [31:0] od24;
  logic [15:0] od8;
`ifdef FIX2FLT_INEXACT_EN
  logic        inex24, inex8;
  logic [15:0] cnt24, cnt8;
  int unsigned cnt24_m, cnt8_m;
`endif

  always #5 clk = ~clk;

  fix_to_custom_float #(.word_length(24), .int_bits(12), .frac_bits(12)) dut24 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready24),
    .out_data(od24), .out_valid(ov24),
`ifdef FIX2FLT_INEXACT_EN
    .out_inexact(inex24), .inexact_cnt(cnt24),
`endif
    .out_ready(out_ready));

  fix_to_custom_float #(.word_length(8), .int_bits(12), .frac_bits(12)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready8),
    .out_data(od8), .out_valid(ov8),
`ifdef FIX2FLT_INEXACT_EN
    .out_inexact(inex8), .inexact_cnt(cnt8),
`endif
    .out_ready(out_ready));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Value = din / 2^12; rounds |value| to wl-1 fraction bits, ties to even.
  function automatic logic [63:0] conv(input logic [23:0] din, input int wl, output bit inex);
    longint unsigned mag, num, q, rem, half;
    int v, e, m;
    bit s;
    m = wl - 1;
    v = int'($signed(din));
    s = (v < 0);
    mag = longint'(s ? -v : v);
    inex = 1'b0;
    if (mag == 0) return 64'd0;
    e = 0;
    while ((mag >> (e + 1)) != 0) e++;
    num  = mag << m;
    q    = num >> e;
    rem  = num - (q << e);
    half = (e > 0) ? (64'd1 << (e - 1)) : 64'd0;
    inex = (rem != 0);
    if (e > 0 && (rem > half || (rem == half && q[0]))) q++;
    if (q == (64'd1 << (m + 1))) begin
      q = q >> 1;
      e++;
    end
    return (64'(s) << (wl + 7)) | (64'(127 + e - 12) << m) | (q - (64'd1 << m));
  endfunction

  typedef struct {
    int unsigned tag;
    logic [31:0] e24;
    logic [15:0] e8;
    bit          i24;
    bit          i8;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] got24[$];
  logic [15:0] got8[$];
  int unsigned adv_cnt;
  bit          prev_stall;
  logic [31:0] prev24;
  logic [15:0] prev8;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      adv_cnt = 0;
      prev_stall = 1'b0;
`ifdef FIX2FLT_INEXACT_EN
      cnt24_m = 0;
      cnt8_m = 0;
`endif
    end else begin
      bit   adv;
      exp_t e;
      bit   x24, x8;
      adv = !ov24 || out_ready;
      chk(in_ready24 == adv && in_ready8 == adv, "in_ready", {in_ready24, in_ready8}, {adv, adv});
      chk(ov8 == ov24, "valid_match", ov8, ov24);
      if (prev_stall)
        chk(ov24 && od24 == prev24 && od8 == prev8, "stall_hold", od24, prev24);
`ifdef FIX2FLT_INEXACT_EN
      chk(cnt24 == 16'(cnt24_m) && cnt8 == 16'(cnt8_m), "inexact_cnt", {cnt24, cnt8},
          {16'(cnt24_m), 16'(cnt8_m)});
`endif
      if (adv) adv_cnt++;
      if (ov24 && out_ready) begin
        got24.push_back(od24);
        got8.push_back(od8);
        if (sb.size() == 0) begin
          chk(1'b0, "spurious_out", od24, 0);
        end else begin
          e = sb.pop_front();
          chk(od24 == e.e24, "data24", od24, e.e24);
          chk(od8 == e.e8, "data8", od8, e.e8);
          chk(adv_cnt == e.tag + 3, "latency", adv_cnt - e.tag, 3);
`ifdef FIX2FLT_INEXACT_EN
          chk(inex24 == e.i24 && inex8 == e.i8, "out_inexact", {inex24, inex8}, {e.i24, e.i8});
          if (e.i24 && cnt24_m < 65535) cnt24_m++;
          if (e.i8 && cnt8_m < 65535) cnt8_m++;
`endif
        end
      end
      if (in_valid && in_ready24) begin
        e.tag = adv_cnt;
        e.e24 = 32'(conv(in_data, 24, x24));
        e.e8  = 16'(conv(in_data, 8, x8));
        e.i24 = x24;
        e.i8  = x8;
        sb.push_back(e);
      end
      prev_stall = ov24 && !out_ready;
      prev24 = od24;
      prev8 = od8;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk(!ov24 && !ov8 && od24 == 0 && od8 == 0, "reset_state", {ov24, od24}, 0);
    chk(in_ready24 && in_ready8, "reset_in_ready", in_ready24, 1);
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 50) begin
      step();
      n++;
    end
    step();
    chk(sb.size() == 0, "drain", sb.size(), 0);
  endtask

  logic [31:0] lit24[5] = '{32'h3F800000, 32'hBF800000, 32'hC5000000, 32'h39800000, 32'h0};
  logic [23:0] vin[5]   = '{24'h001000, 24'hFFF000, 24'h800000, 24'h000001, 24'h000000};
  logic [15:0] lit8[3]  = '{16'h3D80, 16'h3D82, 16'h3E00};
  logic [23:0] vin8[3]  = '{24'h000101, 24'h000103, 24'h0001FF};
  bit          pat[4]   = '{1'b1, 1'b0, 1'b1, 1'b0};
  bit          orpat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    bit          x;
    int          start, k, cyc;
    bit          acc;
    bit          ovs[8];
    logic [23:0] samp[8];

    chk(conv(24'h001000, 24, x) == 64'h3F800000, "model_one", conv(24'h001000, 24, x), 64'h3F800000);
    chk(conv(24'h800000, 24, x) == 64'hC5000000, "model_minneg", conv(24'h800000, 24, x), 64'hC5000000);
    chk(conv(24'h0001FF, 8, x) == 64'h3E00 && x, "model_carry", conv(24'h0001FF, 8, x), 64'h3E00);

    do_reset();

    // Directed vectors, consecutive cycles.
    start = got24.size();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = vin[i];
      step();
    end
    drain();
    chk(got24.size() == start + 5, "directed_count", got24.size() - start, 5);
    for (int i = 0; i < 5; i++)
      if (got24.size() > start + i)
        chk(got24[start+i] == lit24[i], "directed24", got24[start+i], lit24[i]);

    // Narrow-word rounding cases.
    do_reset();
    start = got8.size();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = vin8[i];
      step();
    end
    drain();
    for (int i = 0; i < 3; i++)
      if (got8.size() > start + i) chk(got8[start+i] == lit8[i], "round8", got8[start+i], lit8[i]);
      else chk(1'b0, "round8_missing", got8.size(), start + i + 1);
`ifdef FIX2FLT_INEXACT_EN
    chk(cnt8 == 16'd3, "inexact_cnt_three", cnt8, 3);
`endif

    // Bubbles.
    for (int i = 0; i < 8; i++) begin
      in_valid = (i < 4) ? pat[i] : 1'b0;
      in_data = 24'h000123 + 24'(i);
      @(negedge clk);
      ovs[i] = ov24;
      step();
    end
    for (int i = 0; i < 4; i++) chk(ovs[i+3] == pat[i], "bubble_valid", ovs[i+3], pat[i]);
    drain();

    // Backpressure with out_ready 1,0,0,1.
    for (int i = 0; i < 8; i++) samp[i] = 24'($urandom_range(1, 24'hFFFFFF));
    start = got24.size();
    k = 0;
    cyc = 0;
    while (k < 8 && cyc < 100) begin
      out_ready = orpat[cyc%4];
      in_valid = 1'b1;
      in_data = samp[k];
      @(negedge clk);
      acc = in_valid && in_ready24;
      step();
      if (acc) k++;
      cyc++;
    end
    chk(k == 8, "bp_accept", k, 8);
    drain();
    chk(got24.size() == start + 8, "bp_count", got24.size() - start, 8);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0: in_data = 24'($urandom());
        1: in_data = 24'($urandom_range(0, 300));
        2: in_data = 24'h1 << $urandom_range(0, 23);
        default: in_data = 24'($signed(24'h800000) + $urandom_range(0, 8));
      endcase
      step();
    end
    drain();

    // Asynchronous reset with three samples in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = 24'h00A000 + 24'(i * 24'h000111);
      step();
    end
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk(!ov24 && !ov8 && od24 == 0 && od8 == 0, "async_reset", {ov24, od24}, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    start = got24.size();
    repeat (6) step();
    chk(got24.size() == start, "no_stale", got24.size() - start, 0);
    in_valid = 1'b1;
    in_data = 24'hFFF800;
    step();
    drain();
    chk(got24.size() == start + 1 && got24[got24.size()-1] == 32'hBF000000, "post_reset",
        got24[got24.size()-1], 32'hBF000000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
